cbd_poly_buf: RTL

Downstream stage of the CBD sampler. It takes the 16 signed 3-bit coefficients produced per sampler beat and reduces each one to its canonical mod-q 12-bit value. It assembles a full 256-coefficient polynomial in one of two ping-pong banks, then streams the polynomial out 4 coefficients per beat over a valid/ready handshake to the NTT/polynomial datapath. The sampler has no backpressure, so the block accepts a full polynomial into the second bank while the first drains.

---
 rtl/cbd_poly_buf.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cbd_poly_buf.sv
// cbd_poly_buf: turns 16 signed 3-bit CBD samples per beat into canonical
// mod-q 12-bit coefficients. Each 256-coefficient polynomial is built in one
// of two ping-pong banks and then streamed out 4 coefficients per beat.
// Ports:
//   i_clk, i_rst         : clock and synchronous active-high reset
//   i_coeffs[47:0]       : 16 x 3-bit signed coefficients, coeff j at [47-3j -: 3]
//   i_coeffs_valid       : input beat present (no backpressure upstream)
//   o_in_ready           : current write bank has room (advisory)
//   o_coeffs[47:0]       : 4 x 12-bit coefficients, coeff k at [47-12k -: 12]
//   o_coeffs_valid       : output beat present
//   i_coeffs_ready       : downstream accepts the output beat
//   o_poly_last          : final (64th) beat of a polynomial
//   o_overflow           : sticky, an input beat arrived while its bank was full
module cbd_poly_buf #(
  parameter int P_Q = 3329
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [47:0] i_coeffs,
  input  logic        i_coeffs_valid,
  output logic        o_in_ready,
  output logic [47:0] o_coeffs,
  output logic        o_coeffs_valid,
  input  logic        i_coeffs_ready,
  output logic        o_poly_last,
  output logic        o_overflow
);

  // Negative samples map to q + x. Adding the 12-bit sign extension of x to q
  // gives exactly that, because the sum wraps modulo 4096.
  function automatic logic [11:0] reduce(input logic [2:0] x);
    logic [11:0] r;
    if (x[2]) r = 12'(P_Q) + {{9{1'b1}}, x};
    else      r = {9'b0, x};
    return r;
  endfunction

  // Coefficient storage, deliberately without reset.
  logic [11:0] mem_q [2][256];

  logic       wr_sel_q, wr_sel_d;
  logic [3:0] wr_cnt_q, wr_cnt_d;
  logic [1:0] full_q,   full_d;
  logic       rd_sel_q, rd_sel_d;
  logic [5:0] rd_cnt_q, rd_cnt_d;
  logic       ovf_q,    ovf_d;

  logic wr_acc;
  logic wr_drop;
  logic xfer;

  assign wr_acc  = i_coeffs_valid && !full_q[wr_sel_q];
  assign wr_drop = i_coeffs_valid &&  full_q[wr_sel_q];
  assign xfer    = full_q[rd_sel_q] && i_coeffs_ready;

  always_comb begin
    wr_sel_d = wr_sel_q;
    wr_cnt_d = wr_cnt_q;
    full_d   = full_q;
    rd_sel_d = rd_sel_q;
    rd_cnt_d = rd_cnt_q;
    ovf_d    = ovf_q;

    if (wr_acc) begin
      wr_cnt_d = wr_cnt_q + 4'd1;
      if (wr_cnt_q == 4'd15) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
      end
    end

    if (wr_drop) ovf_d = 1'b1;

    // The fill and drain never target the same bank on the same cycle, so
    // these two updates to full_d touch different bits.
    if (xfer) begin
      rd_cnt_d = rd_cnt_q + 6'd1;
      if (rd_cnt_q == 6'd63) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_sel_q <= 1'b0;
      wr_cnt_q <= 4'd0;
      full_q   <= 2'b00;
      rd_sel_q <= 1'b0;
      rd_cnt_q <= 6'd0;
      ovf_q    <= 1'b0;
    end else begin
      wr_sel_q <= wr_sel_d;
      wr_cnt_q <= wr_cnt_d;
      full_q   <= full_d;
      rd_sel_q <= rd_sel_d;
      rd_cnt_q <= rd_cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Each input beat fills indices 16*wr_cnt .. 16*wr_cnt+15 in one edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_acc) begin
      for (int j = 0; j < 16; j++) begin
        mem_q[wr_sel_q][{wr_cnt_q, 4'(j)}] <= reduce(i_coeffs[47-3*j -: 3]);
      end
    end
  end

  assign o_coeffs_valid = full_q[rd_sel_q];
  assign o_poly_last    = full_q[rd_sel_q] && (rd_cnt_q == 6'd63);
  assign o_in_ready     = !full_q[wr_sel_q];
  assign o_overflow     = ovf_q;

  // Output is a direct read of registered state, so it is stable through stalls.
  always_comb begin
    o_coeffs = '0;
    if (full_q[rd_sel_q]) begin
      for (int k = 0; k < 4; k++) begin
        o_coeffs[47-12*k -: 12] = mem_q[rd_sel_q][{rd_cnt_q, 2'(k)}];
      end
    end
  end

endmodule
